apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 32: address width of the request and APB address.
REQ-002 Parameter APB_DATA_WIDTH, default 32: width of the write data, read data and response data.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum number of ACCESS cycles before the transfer is aborted; 0 disables the timeout.
REQ-004 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- pclk_i in 1: single clock; all state changes on its rising edge.
- presetn_i in 1: reset, asynchronous and active-low.
- req_valid_i in 1: command valid.
- req_ready_o out 1: command accepted when both valid and ready are high.
- req_addr_i in APB_ADDR_WIDTH: command address.
- req_write_i in 1: 1 = write, 0 = read.
- req_wdata_i in APB_DATA_WIDTH: write data.
- rsp_valid_o out 1: response valid.
- rsp_ready_i in 1: response consumed.
- rsp_rdata_o out APB_DATA_WIDTH: read data.
- rsp_err_o out 1: transfer error.
- rsp_timeout_o out 1: error caused by timeout.
- psel_o, penable_o, pwrite_o out 1: APB control.
- paddr_o out APB_ADDR_WIDTH: APB address.
- pwdata_o out APB_DATA_WIDTH: APB write data.
- prdata_i in APB_DATA_WIDTH: APB read data.
- pready_i, pslverr_i in 1: APB completer response.

Function
REQ-005 The block SHALL implement a state machine with the states IDLE, SETUP, ACCESS and RESP.
REQ-006 req_ready_o SHALL be 1 only in IDLE; a handshake in IDLE SHALL register addr, write and wdata and move to SETUP on the next edge.
REQ-007 In SETUP, psel_o SHALL be 1 and penable_o 0 for exactly one cycle, then the state SHALL move to ACCESS.
REQ-008 In ACCESS, psel_o and penable_o SHALL both be 1.
- pready_i and pslverr_i SHALL be sampled only in ACCESS.
- pslverr_i SHALL be ignored while pready_i is 0.
REQ-009 On pready_i=1 in ACCESS, the block SHALL register the response and go to RESP:
- rsp_err_o = pslverr_i.
- rsp_timeout_o = 0.
- rsp_rdata_o = prdata_i for reads, and all zeros for writes.
REQ-010 paddr_o, pwrite_o and pwdata_o SHALL be stable from SETUP through the last ACCESS cycle, and SHALL hold their last values in IDLE and RESP.
REQ-011 A counter SHALL count ACCESS cycles starting at 1.
- If the count reaches TIMEOUT_CYCLES with pready_i=0, the block SHALL go to RESP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
- psel_o and penable_o SHALL be 0 from the next cycle.
REQ-012 If pready_i=1 in the same cycle the timeout count is reached, the block SHALL complete normally and SHALL NOT flag a timeout.
REQ-013 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; with TIMEOUT_CYCLES=0, ACCESS SHALL wait indefinitely.
REQ-014 In RESP, rsp_valid_o SHALL be 1 and the response fields SHALL be stable until rsp_ready_i=1, then the state SHALL go to IDLE.
REQ-015 psel_o SHALL be 0 in IDLE and RESP; penable_o SHALL be 1 only in ACCESS.
REQ-016 Minimum transfer time SHALL be 4 cycles from request handshake to the return to IDLE (accept, SETUP, one ACCESS, RESP with rsp_ready_i=1).
REQ-017 Only one transfer SHALL be outstanding; no new command SHALL be accepted before the response handshake.

Reset
REQ-018 presetn_i=0 SHALL force IDLE asynchronously and zero every output except req_ready_o.
- Zeroed outputs: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o.
- req_ready_o SHALL be 0 while presetn_i=0 and 1 from the first clock edge after release.
REQ-019 Reset asserted mid-transfer SHALL drop psel_o and penable_o immediately and SHALL discard the transfer with no response.

Verification
REQ-020 Write addr=0x1000_0004, wdata=0xDEAD_BEEF, pready_i=1 at the first ACCESS cycle -> psel_o 1 for 2 cycles, penable_o 1 for 1 cycle, then rsp_valid_o=1, rsp_err_o=0, rsp_rdata_o=0.
REQ-021 Read addr=0x2000_0010, pready_i held 0 for 3 ACCESS cycles then 1 with prdata_i=0x1234_5678 -> paddr_o stable throughout, rsp_rdata_o=0x1234_5678, rsp_err_o=0.
REQ-022 Read with pready_i=1 and pslverr_i=1 -> rsp_err_o=1, rsp_timeout_o=0.
REQ-023 TIMEOUT_CYCLES=16, pready_i never asserted -> exactly 16 ACCESS cycles, then psel_o=0, rsp_err_o=1, rsp_timeout_o=1; a second run with pready_i=1 in ACCESS cycle 16 -> normal completion.
REQ-024 rsp_ready_i held 0 for 5 cycles with req_valid_i=1 -> req_ready_o=0 and response held stable; the next command is accepted in the cycle after rsp_ready_i=1.
REQ-025 presetn_i pulsed low during ACCESS -> psel_o and penable_o fall without a clock edge, no rsp_valid_o, and req_ready_o=1 after release.

Source files
------------

// File: rtl/apb_master_if.sv
// Bundle of the request/response handshake and APB bus signals for apb_master.
// The master modport is the block's view; the slave modport is the requester/completer side.
interface apb_master_if #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);
   logic                      req_valid_i;
   logic                      req_ready_o;
   logic [APB_ADDR_WIDTH-1:0] req_addr_i;
   logic                      req_write_i;
   logic [APB_DATA_WIDTH-1:0] req_wdata_i;
   logic                      rsp_valid_o;
   logic                      rsp_ready_i;
   logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
   logic                      rsp_err_o;
   logic                      rsp_timeout_o;
   logic                      psel_o;
   logic                      penable_o;
   logic                      pwrite_o;
   logic [APB_ADDR_WIDTH-1:0] paddr_o;
   logic [APB_DATA_WIDTH-1:0] pwdata_o;
   logic [APB_DATA_WIDTH-1:0] prdata_i;
   logic                      pready_i;
   logic                      pslverr_i;

   modport master (
      input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
      input  prdata_i, pready_i, pslverr_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
   );

   modport slave (
      output req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
      output prdata_i, pready_i, pslverr_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
   );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: takes one command, runs SETUP/ACCESS with an
// optional ACCESS-cycle timeout, and holds the response until it is consumed.
module apb_master #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic         pclk_i,
   input  logic         presetn_i,
   apb_master_if.master bus
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic                      r_started;
   logic [CNT_W-1:0]          r_count;
   logic [APB_ADDR_WIDTH-1:0] r_addr;
   logic                      r_write;
   logic [APB_DATA_WIDTH-1:0] r_wdata;
   logic [APB_DATA_WIDTH-1:0] r_rspRdata;
   logic                      r_rspErr;
   logic                      r_rspTimeout;
   logic                      w_accept;
   logic                      w_done;
   logic                      w_timeout;

   assign w_accept  = (r_state == IDLE) && r_started && bus.req_valid_i;
   assign w_done    = (r_state == ACCESS) && bus.pready_i;
   assign w_timeout = TIMEOUT_ON && (r_state == ACCESS) && !bus.pready_i &&
                      (r_count == TIMEOUT_VAL);

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = SETUP;
         SETUP:   w_next = ACCESS;
         ACCESS:  if (w_done || w_timeout) w_next = RESP;
         RESP:    if (bus.rsp_ready_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Keeps req_ready_o low until the first edge after reset release
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
      end
   end

   // ACCESS-cycle counter: reads 1 in the first ACCESS cycle and saturates at the limit
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_count <= '0;
      end else if (r_state == SETUP) begin
         r_count <= CNT_W'(1);
      end else if ((r_state == ACCESS) && (r_count != TIMEOUT_VAL)) begin
         r_count <= r_count + 1'b1;
      end
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_addr  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_addr  <= bus.req_addr_i;
         r_write <= bus.req_write_i;
         r_wdata <= bus.req_wdata_i;
      end
   end

   // Completion wins over timeout when pready arrives on the limit cycle
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_rspRdata   <= '0;
         r_rspErr     <= 1'b0;
         r_rspTimeout <= 1'b0;
      end else if (w_done) begin
         r_rspRdata   <= r_write ? '0 : bus.prdata_i;
         r_rspErr     <= bus.pslverr_i;
         r_rspTimeout <= 1'b0;
      end else if (w_timeout) begin
         r_rspRdata   <= '0;
         r_rspErr     <= 1'b1;
         r_rspTimeout <= 1'b1;
      end
   end

   assign bus.req_ready_o   = (r_state == IDLE) && r_started;
   assign bus.psel_o        = (r_state == SETUP) || (r_state == ACCESS);
   assign bus.penable_o     = (r_state == ACCESS);
   assign bus.pwrite_o      = r_write;
   assign bus.paddr_o       = r_addr;
   assign bus.pwdata_o      = r_wdata;
   assign bus.rsp_valid_o   = (r_state == RESP);
   assign bus.rsp_rdata_o   = r_rspRdata;
   assign bus.rsp_err_o     = r_rspErr;
   assign bus.rsp_timeout_o = r_rspTimeout;
endmodule
